oled_spi_tx: RTL

- Byte-level serial transmitter for the SSD1306-style OLED on the board, directly downstream of the OLED controller sequencer.
- The sequencer pushes command/data bytes, each tagged with a D/C flag, into a small FIFO.
- The block shifts each byte out MSB-first on SDIN/SCLK (SPI mode 3, write-only) and holds DC stable across the byte.
- It provides back-pressure to the sequencer and pulses a completion strobe after each byte.

---
 rtl/oled_spi_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/oled_spi_tx.sv
// Byte-level SPI transmitter for the SSD1306-style OLED panel.
// Bytes tagged with a D/C flag are queued in a small FIFO. Each byte is
// shifted out MSB-first in SPI mode 3 (SCLK idles high, the panel samples on
// the rising edge). DC is held stable for the whole byte.
module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  input  logic          tx_dc,
  output logic          tx_ready,
  output logic          busy,
  output logic          byte_done,
  output logic [CW-1:0] fifo_count,
  output logic          SDIN,
  output logic          SCLK,
  output logic          DC
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH
  } state_t;

  // FIFO storage and bookkeeping; each entry is {dc, data}
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  logic [8:0]    fifoHead;

  // Shifter state and registered serial outputs
  state_t        state_q, state_d;
  logic [7:0]    divCnt_q, divCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;
  logic          dc_q, dc_d;
  logic          byteDone_q, byteDone_d;
  logic          divEnd;

  // The ready flag deliberately ignores a same-cycle pop, so a full FIFO never accepts
  assign tx_ready   = rst & (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  assign fifoHead   = mem_q[rdPtr_q];
  assign busy       = rst & ((count_q != '0) | (state_q != IDLE));
  assign fifo_count = count_q;
  assign SDIN       = sdin_q;
  assign SCLK       = sclk_q;
  assign DC         = dc_q;
  assign byte_done  = byteDone_q;
  assign divEnd     = (divCnt_q == 8'(CLK_DIV - 1));

  // Write port of the FIFO memory; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {tx_dc, tx_data};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Shifter state register together with the registered serial outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      divCnt_q   <= '0;
      bitCnt_q   <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b1;
      sdin_q     <= 1'b0;
      dc_q       <= 1'b0;
      byteDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      bitCnt_q   <= bitCnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      sdin_q     <= sdin_d;
      dc_q       <= dc_d;
      byteDone_q <= byteDone_d;
    end
  end

  // Next-state logic: DC only moves in IDLE (SCLK high), SDIN only moves as SCLK falls
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    bitCnt_d   = bitCnt_q;
    shreg_d    = shreg_q;
    sclk_d     = sclk_q;
    sdin_d     = sdin_q;
    dc_d       = dc_q;
    byteDone_d = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (count_q != '0) begin
          pop      = 1'b1;
          shreg_d  = fifoHead[7:0];
          dc_d     = fifoHead[8];
          bitCnt_d = 3'd7;
          divCnt_d = '0;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        if (divEnd) begin
          divCnt_d = '0;
          sclk_d   = 1'b0;
          sdin_d   = shreg_q[7];
          state_d  = LOW;
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      LOW: begin
        if (divEnd) begin
          divCnt_d = '0;
          sclk_d   = 1'b1;
          state_d  = HIGH;
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      HIGH: begin
        if (divEnd) begin
          divCnt_d = '0;
          if (bitCnt_q == 3'd0) begin
            byteDone_d = 1'b1;
            state_d    = IDLE;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitCnt_d = bitCnt_q - 3'd1;
            sclk_d   = 1'b0;
            sdin_d   = shreg_q[6];
            state_d  = LOW;
          end
        end else begin
          divCnt_d = divCnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
